// File: rtl/rs_syndrome_stream_if.sv
// Stream bundle for the Reed-Solomon syndrome calculator: a symbol input
// stream and a syndrome output stream, each with valid/ready handshaking.
interface rs_syndrome_stream_if #(
    parameter int SYMBOL_WIDTH = 3,
    parameter int NUM_SYN      = 2
) ();
    logic                            in_valid;
    logic                            in_ready;
    logic [SYMBOL_WIDTH-1:0]         in_symbol;
    logic                            syn_valid;
    logic                            syn_ready;
    logic [NUM_SYN*SYMBOL_WIDTH-1:0] syndromes;
    logic                            syn_nonzero;

    // Upstream producer / downstream consumer side (e.g. a testbench)
    modport master (
        output in_valid,
        output in_symbol,
        output syn_ready,
        input  in_ready,
        input  syn_valid,
        input  syndromes,
        input  syn_nonzero
    );

    // Syndrome calculator side
    modport slave (
        input  in_valid,
        input  in_symbol,
        input  syn_ready,
        output in_ready,
        output syn_valid,
        output syndromes,
        output syn_nonzero
    );
endinterface

// File: rtl/rs_syndrome_stream.sv
// Symbol-serial Reed-Solomon syndrome calculator for RS(N,K) over GF(2^M).
// Each received symbol (highest degree first) is folded into NUM_SYN Horner
// accumulators, one per root alpha^(FCR+j). When the last symbol of a codeword
// arrives, the final values move into a separate output register so the next
// codeword can stream in while the previous syndromes wait for the consumer.
module rs_syndrome_stream #(
    parameter int                    SYMBOL_WIDTH = 3,
    parameter int                    N            = 7,
    parameter int                    NUM_SYN      = 2,
    parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = 4'b1011,
    parameter int                    FCR          = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    rs_syndrome_stream_if.slave  bus
);
    localparam int M     = SYMBOL_WIDTH;
    localparam int Q     = (1 << M) - 1;
    localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    // Multiply by x modulo the primitive polynomial; the x^M term of the
    // polynomial is implicit in the carry-out test.
    function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] a);
        logic [M-1:0] r;
        r = a << 1;
        if (a[M-1]) begin
            r = r ^ PRIM_POLY[M-1:0];
        end
        return r;
    endfunction

    // Shift-and-add GF(2^M) product; with a constant b this reduces to a
    // fixed XOR network.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                            input logic [M-1:0] b);
        logic [M-1:0] r;
        r = '0;
        for (int i = M - 1; i >= 0; i--) begin
            r = gf_xtime(r);
            if (b[i]) begin
                r = r ^ a;
            end
        end
        return r;
    endfunction

    // alpha^e with alpha = x; the exponent is reduced modulo the group order.
    function automatic logic [M-1:0] gf_pow(input int e);
        logic [M-1:0] r;
        r = M'(1);
        for (int i = 0; i < (e % Q); i++) begin
            r = gf_xtime(r);
        end
        return r;
    endfunction

    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [NUM_SYN-1:0][M-1:0]     acc_q, acc_d;
    logic [NUM_SYN-1:0][M-1:0]     horner;
    logic [M-1:0]                  mul_out [NUM_SYN];
    logic [NUM_SYN*M-1:0]          syn_q, syn_d;
    logic                          syn_valid_q, syn_valid_d;
    logic                          syn_nonzero_q, syn_nonzero_d;
    logic                          in_ready_w;
    logic                          in_beat;
    logic                          out_beat;
    logic                          last_beat;

    // Constant multipliers by alpha^(FCR+j), one per syndrome
    for (genvar j = 0; j < NUM_SYN; j++) begin : g_root
        localparam logic [M-1:0] ALPHA_J = gf_pow(FCR + j);
        assign mul_out[j] = gf_mul(acc_q[j], ALPHA_J);
    end

    // Handshake decode; only the closing symbol can stall, and only while
    // the output register is full and not being drained this cycle.
    always_comb begin
        in_ready_w = !(syn_valid_q && !bus.syn_ready && (cnt_q == LAST));
        in_beat    = bus.in_valid && in_ready_w;
        out_beat   = syn_valid_q && bus.syn_ready;
        last_beat  = in_beat && (cnt_q == LAST);
    end

    // Horner step: the first symbol of a codeword restarts each accumulator
    always_comb begin
        horner = '0;
        for (int j = 0; j < NUM_SYN; j++) begin
            if (cnt_q == '0) begin
                horner[j] = bus.in_symbol;
            end else begin
                horner[j] = mul_out[j] ^ bus.in_symbol;
            end
        end
    end

    // Next-state for the symbol counter, accumulators and output register
    always_comb begin
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        syn_d         = syn_q;
        syn_valid_d   = syn_valid_q;
        syn_nonzero_d = syn_nonzero_q;

        if (in_beat) begin
            acc_d = horner;
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A fresh load wins over a drain landing on the same edge
        if (last_beat) begin
            syn_d         = horner;
            syn_valid_d   = 1'b1;
            syn_nonzero_d = |horner;
        end else if (out_beat) begin
            syn_d         = '0;
            syn_valid_d   = 1'b0;
            syn_nonzero_d = 1'b0;
        end
    end

    // State registers; reset drops any partial codeword and pending result
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            acc_q         <= '0;
            syn_q         <= '0;
            syn_valid_q   <= 1'b0;
            syn_nonzero_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            syn_q         <= syn_d;
            syn_valid_q   <= syn_valid_d;
            syn_nonzero_q <= syn_nonzero_d;
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.syn_valid   = syn_valid_q;
    assign bus.syndromes   = syn_q;
    assign bus.syn_nonzero = syn_nonzero_q;

endmodule

// File: tb/tb_rs_syndrome_stream.sv
// Scoreboard bench for rs_syndrome_stream with GF(8) defaults. Expected
// syndromes come from direct polynomial evaluation using log/antilog tables.
module tb_rs_syndrome_stream;
    localparam int M    = 3;
    localparam int N    = 7;
    localparam int NS   = 2;
    localparam int FCR  = 1;
    localparam int POLY = 'b1011;
    localparam int Q    = (1 << M) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rs_syndrome_stream_if #(.SYMBOL_WIDTH(M), .NUM_SYN(NS)) bus ();

    rs_syndrome_stream #(
        .SYMBOL_WIDTH(M), .N(N), .NUM_SYN(NS),
        .PRIM_POLY(4'b1011), .FCR(FCR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int exp_t [0:255];
    int log_t [0:255];
    int frame_syms [N];
    logic [NS*M-1:0] exp_q [$];
    int tests = 0;
    int fails = 0;
    int stalls = 0;
    int out_beats = 0;
    int rdy_mode = 1;

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % Q];
    endfunction

    // S_j = sum_i r_i * alpha^((FCR+j)*i); frame_syms[k] has degree N-1-k
    function automatic logic [NS*M-1:0] model_syn();
        logic [NS*M-1:0] r;
        r = '0;
        for (int j = 0; j < NS; j++) begin
            int s;
            s = 0;
            for (int k = 0; k < N; k++) begin
                s = s ^ gmul(frame_syms[k], exp_t[((FCR + j) * (N - 1 - k)) % Q]);
            end
            r[j*M +: M] = M'(s);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // syn_ready driver: 0 low, 1 high, 2 random, 3/4 single-cycle pulse
    always @(negedge clk) begin
        case (rdy_mode)
            0: bus.syn_ready = 1'b0;
            1: bus.syn_ready = 1'b1;
            2: bus.syn_ready = 1'($urandom_range(0, 1));
            3: begin bus.syn_ready = 1'b1; rdy_mode = 4; end
            default: begin bus.syn_ready = 1'b0; rdy_mode = 0; end
        endcase
    end

    // Monitor: pops and compares on every output beat; also checks that a
    // stalled result stays put.
    logic            held_v = 1'b0;
    logic [NS*M-1:0] held_syn;
    logic            held_nz;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v && bus.syn_valid) begin
                chk("stable_syn", 32'(bus.syndromes), 32'(held_syn));
                chk("stable_nz", 32'(bus.syn_nonzero), 32'(held_nz));
            end
            held_v = 1'b0;
            if (bus.syn_valid && bus.syn_ready) begin
                out_beats++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(bus.syn_valid), 32'(0));
                end else begin
                    logic [NS*M-1:0] e;
                    e = exp_q.pop_front();
                    chk("syndromes", 32'(bus.syndromes), 32'(e));
                    chk("syn_nonzero", 32'(bus.syn_nonzero), 32'(e != '0));
                end
            end else if (bus.syn_valid) begin
                held_v   = 1'b1;
                held_syn = bus.syndromes;
                held_nz  = bus.syn_nonzero;
            end
        end
    end

    task automatic send(input int sym);
        int w;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_symbol = M'(sym);
        w = 0;
        forever begin
            #1;
            if (bus.in_ready) begin
                @(posedge clk);
                break;
            end
            stalls++;
            w++;
            if (w > 1000) begin
                chk("send_timeout", 32'(w), 32'(0));
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap_max);
        exp_q.push_back(model_syn());
        for (int k = 0; k < N; k++) begin
            send(frame_syms[k]);
            if (k < N - 1) repeat ($urandom_range(0, gap_max)) idle();
        end
        #1;
        chk("latency_valid", 32'(bus.syn_valid), 32'(1));
    endtask

    task automatic rand_frame();
        for (int k = 0; k < N; k++) frame_syms[k] = int'($urandom_range(0, Q));
    endtask

    task automatic set_frame(input int s6, input int s5, input int s4, input int s3,
                             input int s2, input int s1, input int s0);
        frame_syms[0] = s6; frame_syms[1] = s5; frame_syms[2] = s4;
        frame_syms[3] = s3; frame_syms[4] = s2; frame_syms[5] = s1;
        frame_syms[6] = s0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(1));
        chk({tag, "_syn_valid"}, 32'(bus.syn_valid), 32'(0));
        chk({tag, "_syndromes"}, 32'(bus.syndromes), 32'(0));
        chk({tag, "_syn_nonzero"}, 32'(bus.syn_nonzero), 32'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic drain();
        int w;
        rdy_mode = 1;
        w = 0;
        while ((exp_q.size() != 0 || bus.syn_valid) && w < 300) begin
            @(negedge clk);
            w++;
        end
        #3;
        chk("drain_done", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        exp_t[0] = 1;
        log_t[1] = 0;
        for (int k = 1; k < Q; k++) begin
            int v;
            v = exp_t[k-1] << 1;
            if ((v & (1 << M)) != 0) v = v ^ POLY;
            exp_t[k] = v;
            log_t[v] = k;
        end

        bus.in_valid  = 1'b0;
        bus.in_symbol = '0;
        bus.syn_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_vals("init");

        // Directed codewords: valid, error at r_0, r_1, r_6
        rdy_mode = 1;
        set_frame(0, 0, 0, 0, 1, 6, 3); send_frame(0);
        set_frame(0, 0, 0, 0, 0, 0, 1); send_frame(0);
        set_frame(0, 0, 0, 0, 0, 1, 0); send_frame(2);
        set_frame(1, 0, 0, 0, 0, 0, 0); send_frame(0);
        idle();
        drain();

        // Backpressure: two back-to-back codewords with syn_ready low
        rdy_mode = 0;
        @(negedge clk);
        stalls = 0;
        rand_frame(); send_frame(0);
        rand_frame();
        exp_q.push_back(model_syn());
        for (int k = 0; k < N - 1; k++) send(frame_syms[k]);
        chk("no_early_stall", 32'(stalls), 32'(0));
        fork
            send(frame_syms[N-1]);
            begin
                repeat (3) @(negedge clk);
                #1;
                chk("last_sym_stalled", 32'(bus.in_ready), 32'(0));
                rdy_mode = 3;
            end
        join
        #1;
        chk("second_loaded", 32'(bus.syn_valid), 32'(1));
        idle();
        drain();

        // Continuous stream of 4 codewords, no bubbles expected
        rdy_mode = 1;
        @(negedge clk);
        stalls = 0;
        out_beats = 0;
        for (int f = 0; f < 4; f++) begin
            rand_frame();
            send_frame(0);
        end
        idle();
        drain();
        chk("cont_no_stall", 32'(stalls), 32'(0));
        chk("cont_out_beats", 32'(out_beats), 32'(4));

        // Random traffic with random gaps and random syn_ready
        rdy_mode = 2;
        for (int f = 0; f < 30; f++) begin
            rand_frame();
            send_frame(3);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        drain();

        // Reset discards an un-accepted result
        rdy_mode = 0;
        set_frame(0, 0, 0, 0, 0, 0, 1); send_frame(0);
        do_reset();
        void'(exp_q.pop_back());
        check_reset_vals("rst_pending");

        // Reset mid-frame, then a clean codeword must give zero syndromes
        rdy_mode = 1;
        for (int k = 0; k < 3; k++) send(int'($urandom_range(1, Q)));
        do_reset();
        check_reset_vals("rst_midframe");
        set_frame(0, 0, 0, 0, 1, 6, 3); send_frame(0);
        idle();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
